// File: rtl/scan_display_mux_pkg.sv
// -----------------------------------------------------------------------------
// scan_display_mux_pkg
// Shared definitions for the multiplexed front-panel scanner:
//   - derived widths computed from the top-level parameters
//   - slot phase boundaries (end of shifting, latch strobe cycle)
//   - state encoding of the serial shifter
// No ports (package).
// -----------------------------------------------------------------------------
package scan_display_mux_pkg;

   // Bits serialised per digit slot: every row carries cathode + segment field.
   function automatic int calc_shift_w(input int n_rows, input int n_digits, input int seg_w);
      return n_rows * (n_digits + seg_w);
   endfunction

   // Width of the digit index; a single-digit panel still gets one bit.
   function automatic int calc_dig_w(input int n_digits);
      return (n_digits > 1) ? $clog2(n_digits) : 1;
   endfunction

   // Slot cycle at which shifting is complete (two clk cycles per bit).
   function automatic int calc_shift_end(input int shift_w);
      return 2 * shift_w;
   endfunction

   // Slot cycle carrying the one-cycle latch strobe.
   function automatic int calc_load_cyc(input int shift_w);
      return 2 * shift_w;
   endfunction

   typedef enum logic {
      SH_IDLE  = 1'b0,
      SH_SHIFT = 1'b1
   } shift_state_e;

endpackage

// File: rtl/scan_shifter.sv
// -----------------------------------------------------------------------------
// scan_shifter
// Serialises one SHIFT_W word MSB first into the driver chain. The start
// cycle already presents the MSB on sdata; every bit gets one low and one high
// sclk cycle, and the latch strobe follows the final rising edge.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        one-cycle request to shift 'word' (ignored while busy)
//   word         word to serialise
//   sclk, sdata  serial clock / data (registered)
//   sload        one-cycle latch strobe after the full word (registered)
//   busy         high while a word is being shifted
// -----------------------------------------------------------------------------
module scan_shifter
   import scan_display_mux_pkg::*;
#(
   parameter int SHIFT_W = 72
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [SHIFT_W-1:0] word,
   output logic               sclk,
   output logic               sdata,
   output logic               sload,
   output logic               busy
);

   localparam int LOAD_CYC = calc_load_cyc(SHIFT_W);
   localparam int CNT_W    = $clog2(LOAD_CYC + 1);

   shift_state_e       state_r, state_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s;
   logic [SHIFT_W-1:0] shreg_r, shreg_s;
   logic               sclk_r, sclk_s;
   logic               sdata_r, sdata_s;
   logic               sload_r, sload_s;

   // Next-state and next-output logic; cnt_r is the phase of the coming cycle.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      shreg_s = shreg_r;
      sclk_s  = sclk_r;
      sdata_s = sdata_r;
      sload_s = 1'b0;
      case (state_r)
         SH_IDLE: begin
            sclk_s = 1'b0;
            if (start) begin
               // MSB leaves immediately; the rest waits in shreg.
               sdata_s = word[SHIFT_W-1];
               shreg_s = word << 1;
               cnt_s   = CNT_W'(1);
               state_s = SH_SHIFT;
            end else begin
               cnt_s = '0;
            end
         end
         SH_SHIFT: begin
            if (cnt_r == CNT_W'(LOAD_CYC)) begin
               sclk_s  = 1'b0;
               sload_s = 1'b1;
               cnt_s   = '0;
               state_s = SH_IDLE;
            end else if (cnt_r[0]) begin
               // Odd phase: rising edge, driver samples the held bit.
               sclk_s = 1'b1;
               cnt_s  = cnt_r + CNT_W'(1);
            end else begin
               sclk_s  = 1'b0;
               sdata_s = shreg_r[SHIFT_W-1];
               shreg_s = shreg_r << 1;
               cnt_s   = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_s = SH_IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= SH_IDLE;
         cnt_r   <= '0;
         shreg_r <= '0;
         sclk_r  <= 1'b0;
         sdata_r <= 1'b0;
         sload_r <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         shreg_r <= shreg_s;
         sclk_r  <= sclk_s;
         sdata_r <= sdata_s;
         sload_r <= sload_s;
      end
   end

   assign sclk  = sclk_r;
   assign sdata = sdata_r;
   assign sload = sload_r;
   assign busy  = (state_r == SH_SHIFT);

endmodule

// File: rtl/scan_display_mux.sv
// -----------------------------------------------------------------------------
// scan_display_mux
// Scans N_DIGITS slots across N_ROWS chained LED-driver rows. Each slot shifts
// one word {row N_ROWS-1 .. row 0}, row = {one-hot cathode, segments}, from a
// double-buffered shadow frame, then PWM-enables the drivers.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   frame_data   segment patterns, row r digit d at [(r*N_DIGITS+d)*SEG_W +: SEG_W]
//   upd_req      load frame_data into the shadow at the next frame boundary
//   upd_ack      one-cycle pulse: shadow loaded
//   bright       PWM brightness, 0 = dark
//   sclk, sdata, sload, sclr_n, soe_n   driver chain pins
//   digit_idx    current slot index
//   frame_done   one-cycle pulse in the last cycle of the last slot
// -----------------------------------------------------------------------------
module scan_display_mux
   import scan_display_mux_pkg::*;
#(
   parameter int N_DIGITS     = 8,
   parameter int N_ROWS       = 3,
   parameter int SEG_W        = 16,
   parameter int DIGIT_CYCLES = 256,
   parameter int BRIGHT_W     = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [N_ROWS*N_DIGITS*SEG_W-1:0]   frame_data,
   input  logic                               upd_req,
   output logic                               upd_ack,
   input  logic [BRIGHT_W-1:0]                bright,
   output logic                               sclk,
   output logic                               sdata,
   output logic                               sload,
   output logic                               sclr_n,
   output logic                               soe_n,
   output logic [calc_dig_w(N_DIGITS)-1:0]    digit_idx,
   output logic                               frame_done
);

   localparam int SHIFT_W   = calc_shift_w(N_ROWS, N_DIGITS, SEG_W);
   localparam int DIG_W     = calc_dig_w(N_DIGITS);
   localparam int SHIFT_END = calc_shift_end(SHIFT_W);
   localparam int ROW_W     = N_DIGITS + SEG_W;
   localparam int FRAME_W   = N_ROWS * N_DIGITS * SEG_W;
   localparam int S_W       = $clog2(DIGIT_CYCLES);

   if (DIGIT_CYCLES < 2 * SHIFT_W + 2) begin : g_cfg_check
      $error("scan_display_mux: DIGIT_CYCLES too small to shift and latch one word");
   end

   logic [S_W-1:0]      s_r;
   logic [DIG_W-1:0]    digit_r;
   logic [FRAME_W-1:0]  shadow_r;
   logic                sclr_n_r, soe_n_r, upd_ack_r, frame_done_r;
   logic [SHIFT_W-1:0]  word_s;
   logic [BRIGHT_W-1:0] pwm_phase;
   logic                last_digit, slot_end, pre_end, blank, shift_busy, accept;

   assign last_digit = (digit_r == DIG_W'(N_DIGITS - 1));
   assign slot_end   = (s_r == S_W'(DIGIT_CYCLES - 1));
   assign pre_end    = (s_r == S_W'(DIGIT_CYCLES - 2));
   assign blank      = (s_r <= S_W'(SHIFT_END));
   // frame_done_r is high exactly in the last cycle of the last slot.
   assign accept     = frame_done_r & upd_req;

   // PWM compares the low slot-counter bits against bright.
   if (S_W >= BRIGHT_W) begin : g_pwm_wide
      assign pwm_phase = s_r[BRIGHT_W-1:0];
   end else begin : g_pwm_narrow
      assign pwm_phase = {{(BRIGHT_W - S_W){1'b0}}, s_r};
   end

   // Slot word assembly: the current digit selects its cathode bit and segments.
   always_comb begin
      word_s = '0;
      for (int r = 0; r < N_ROWS; r++) begin
         for (int d = 0; d < N_DIGITS; d++) begin
            word_s[r*ROW_W + SEG_W + d] = (digit_r == DIG_W'(d));
            word_s[r*ROW_W +: SEG_W] = word_s[r*ROW_W +: SEG_W]
               | ({SEG_W{digit_r == DIG_W'(d)}} & shadow_r[(r*N_DIGITS + d)*SEG_W +: SEG_W]);
         end
      end
   end

   // Slot/digit counters, shadow buffer, handshake, PWM and clear registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_r          <= '0;
         digit_r      <= '0;
         shadow_r     <= '0;
         sclr_n_r     <= 1'b0;
         soe_n_r      <= 1'b1;
         upd_ack_r    <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         sclr_n_r <= 1'b1;
         if (slot_end) begin
            s_r     <= '0;
            digit_r <= last_digit ? '0 : digit_r + DIG_W'(1);
         end else begin
            s_r     <= s_r + S_W'(1);
            digit_r <= digit_r;
         end
         soe_n_r      <= blank ? 1'b1 : ~(pwm_phase < bright);
         frame_done_r <= last_digit & pre_end;
         upd_ack_r    <= accept;
         if (accept) begin
            shadow_r <= frame_data;
         end else begin
            shadow_r <= shadow_r;
         end
      end
   end

   scan_shifter #(
      .SHIFT_W (SHIFT_W)
   ) u_shifter (
      .clk   (clk),
      .rst_n (rst_n),
      .start ((s_r == '0) & ~shift_busy),
      .word  (word_s),
      .sclk  (sclk),
      .sdata (sdata),
      .sload (sload),
      .busy  (shift_busy)
   );

   assign sclr_n     = sclr_n_r;
   assign soe_n      = soe_n_r;
   assign upd_ack    = upd_ack_r;
   assign frame_done = frame_done_r;
   assign digit_idx  = digit_r;

endmodule

// File: tb/tb_scan_display_mux.sv
// -----------------------------------------------------------------------------
// tb_scan_display_mux
// Randomised bench for scan_display_mux with a frame-level reference model.
// The driver computes, per clock edge, the expected pin state from slot/frame
// arithmetic and queues it; slot words are queued at each slot start. A monitor
// reassembles shifted words on sclk rises and checks them at every sload.
// -----------------------------------------------------------------------------
module tb_scan_display_mux;

   localparam int N_DIGITS     = 8;
   localparam int N_ROWS       = 3;
   localparam int SEG_W        = 16;
   localparam int DIGIT_CYCLES = 256;
   localparam int BRIGHT_W     = 4;
   localparam int SHIFT_W      = N_ROWS * (N_DIGITS + SEG_W);
   localparam int ROW_W        = N_DIGITS + SEG_W;
   localparam int DIG_W        = 3;
   localparam int FRAME_W      = N_ROWS * N_DIGITS * SEG_W;
   localparam int FRAME_CYC    = N_DIGITS * DIGIT_CYCLES;

   typedef struct packed {
      logic             rst;
      logic             sclr_n;
      logic             soe_n;
      logic             frame_done;
      logic             upd_ack;
      logic [DIG_W-1:0] digit;
   } cyc_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [FRAME_W-1:0] frame_data;
   logic               upd_req;
   logic               upd_ack;
   logic [BRIGHT_W-1:0] bright;
   logic               sclk, sdata, sload, sclr_n, soe_n, frame_done;
   logic [DIG_W-1:0]   digit_idx;

   int checks = 0;
   int errors = 0;
   int e = 0;
   logic [FRAME_W-1:0] m_shadow = '0;
   cyc_t exp_cyc_q[$];
   logic [SHIFT_W-1:0] exp_word_q[$];

   scan_display_mux #(
      .N_DIGITS     (N_DIGITS),
      .N_ROWS       (N_ROWS),
      .SEG_W        (SEG_W),
      .DIGIT_CYCLES (DIGIT_CYCLES),
      .BRIGHT_W     (BRIGHT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_data (frame_data),
      .upd_req    (upd_req),
      .upd_ack    (upd_ack),
      .bright     (bright),
      .sclk       (sclk),
      .sdata      (sdata),
      .sload      (sload),
      .sclr_n     (sclr_n),
      .soe_n      (soe_n),
      .digit_idx  (digit_idx),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [SHIFT_W-1:0] act, input logic [SHIFT_W-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
      end
   endtask

   // Word for digit d: rows from top to bottom, each {one-hot cathode, segments}.
   function automatic logic [SHIFT_W-1:0] build_word(input logic [FRAME_W-1:0] sh, input int d);
      logic [SHIFT_W-1:0] w = '0;
      logic [N_DIGITS-1:0] cath;
      cath = N_DIGITS'(1) << d;
      for (int r = N_ROWS - 1; r >= 0; r--) begin
         w = (w << ROW_W) | {{(SHIFT_W - ROW_W){1'b0}}, cath, sh[(r*N_DIGITS + d)*SEG_W +: SEG_W]};
      end
      return w;
   endfunction

   task automatic randomize_frame();
      for (int j = 0; j < N_ROWS * N_DIGITS; j++) begin
         frame_data[j*SEG_W +: SEG_W] = 16'($urandom);
      end
   endtask

   // Apply the inputs already set, queue expectations for the coming edge.
   task automatic step(input bit do_rst);
      cyc_t c;
      int s, d;
      rst_n = ~do_rst;
      if (do_rst) begin
         c.rst = 1'b1; c.sclr_n = 1'b0; c.soe_n = 1'b1;
         c.frame_done = 1'b0; c.upd_ack = 1'b0; c.digit = '0;
         e = 0;
         m_shadow = '0;
         exp_word_q.delete();
      end else begin
         s = e % DIGIT_CYCLES;
         d = (e / DIGIT_CYCLES) % N_DIGITS;
         if (s == 0) exp_word_q.push_back(build_word(m_shadow, d));
         c.rst        = 1'b0;
         c.sclr_n     = 1'b1;
         c.soe_n      = (s <= 2 * SHIFT_W) ? 1'b1 : (((s % 16) < int'(bright)) ? 1'b0 : 1'b1);
         c.frame_done = (s == DIGIT_CYCLES - 2) && (d == N_DIGITS - 1);
         c.upd_ack    = (s == DIGIT_CYCLES - 1) && (d == N_DIGITS - 1) && upd_req;
         c.digit      = DIG_W'(((e + 1) / DIGIT_CYCLES) % N_DIGITS);
         if (c.upd_ack) m_shadow = frame_data;
         e++;
      end
      exp_cyc_q.push_back(c);
      @(negedge clk);
   endtask

   // Monitor: per-cycle pin checks plus word reassembly on sclk rises.
   initial begin
      cyc_t c;
      logic [SHIFT_W-1:0] acc = '0;
      int nbits = 0;
      logic prev_sclk = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_cyc_q.size() == 0) begin
            check("cycle_queue_nonempty", 0, 1);
         end else begin
            c = exp_cyc_q.pop_front();
            if (c.rst) begin
               check("rst_sclk", sclk, 0);
               check("rst_sdata", sdata, 0);
               check("rst_sload", sload, 0);
               check("rst_sclr_n", sclr_n, 0);
               check("rst_soe_n", soe_n, 1);
               check("rst_upd_ack", upd_ack, 0);
               check("rst_frame_done", frame_done, 0);
               check("rst_digit_idx", digit_idx, 0);
               acc = '0;
               nbits = 0;
               prev_sclk = 1'b0;
            end else begin
               check("sclr_n", sclr_n, c.sclr_n);
               check("soe_n", soe_n, c.soe_n);
               check("frame_done", frame_done, c.frame_done);
               check("upd_ack", upd_ack, c.upd_ack);
               check("digit_idx", digit_idx, c.digit);
               if (sclk && !prev_sclk) begin
                  acc = {acc[SHIFT_W-2:0], sdata};
                  nbits++;
               end
               if (sload) begin
                  if (exp_word_q.size() == 0) begin
                     check("unexpected_sload", 1, 0);
                  end else begin
                     check("slot_word", acc, exp_word_q.pop_front());
                     check("sclk_rises_per_slot", nbits, SHIFT_W);
                  end
                  nbits = 0;
               end
               prev_sclk = sclk;
            end
         end
      end
   end

   // Stimulus: five frame modes cycling, one reset in the middle of a shift.
   initial begin
      int s, d, mode;
      bit did_rst = 1'b0;
      upd_req = 1'b0;
      bright = '0;
      frame_data = '0;
      repeat (3) step(1'b1);
      frame_data[15:0] = 16'hA5C3;
      while (!(e >= 7 * FRAME_CYC && (e % DIGIT_CYCLES) == 200)) begin
         if (!did_rst && e == 2 * FRAME_CYC + 2 * DIGIT_CYCLES + 40) begin
            repeat (3) step(1'b1);
            did_rst = 1'b1;
         end
         s = e % DIGIT_CYCLES;
         d = (e / DIGIT_CYCLES) % N_DIGITS;
         mode = (e / FRAME_CYC) % 5;
         case (mode)
            0: begin
               // Short request pulse straddling the frame boundary.
               bright = 4'd0;
               upd_req = ((d == N_DIGITS - 1) && (s >= DIGIT_CYCLES - 4)) || ((d == 0) && (s < 4));
            end
            1: begin
               // New data without a request must not reach the panel.
               bright = 4'd15;
               upd_req = 1'b0;
               if (d == 4 && s == 0) randomize_frame();
            end
            2: begin
               bright = 4'd4;
               upd_req = 1'b1;
               if (s == 100) randomize_frame();
            end
            3: begin
               // Request dropped just before the boundary is lost.
               bright = 4'($urandom_range(0, 15));
               upd_req = (d == N_DIGITS - 1) && (s >= DIGIT_CYCLES - 12) && (s < DIGIT_CYCLES - 3);
               if (s == 7) randomize_frame();
            end
            default: begin
               if (s % 32 == 0) bright = 4'($urandom_range(0, 15));
               upd_req = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 63) == 0) randomize_frame();
            end
         endcase
         step(1'b0);
      end
      check("pending_words", exp_word_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
